ghost_step_sequencer: RTL



---
 rtl/ghost_step_sequencer_pkg.sv | 19 +
 rtl/ghost_step_sequencer_mode_timer.sv | 54 +++++
 rtl/ghost_step_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ghost_step_sequencer_pkg.sv
// ghost_step_sequencer_pkg: playfield geometry, mode and sequencer state encodings
package ghost_step_sequencer_pkg;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);
  typedef enum logic [1:0] {
    MODE_SCATTER = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_FRIGHT  = 2'd2
  } mode_e;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/ghost_step_sequencer_mode_timer.sv
// ghost_mode_timer: scatter/chase phase timer with frightened override and mode save/restore
module ghost_mode_timer
  import ghost_step_sequencer_pkg::*;
#(
  parameter int SCATTER_TICKS = 70,
  parameter int CHASE_TICKS   = 200,
  parameter int FRIGHT_TICKS  = 60
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  move_tick,
  input  logic  power_pellet,
  output mode_e mode
);
  localparam int RW = $clog2((SCATTER_TICKS > CHASE_TICKS ? SCATTER_TICKS : CHASE_TICKS) + 1);
  localparam int FW = $clog2(FRIGHT_TICKS + 1);
  mode_e mode_q, mode_d, saved_q, saved_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  // The scatter/chase remaining count is simply left untouched during fright, which
  // is equivalent to saving and restoring it.
  always_comb begin
    mode_d  = mode_q;
    saved_d = saved_q;
    rem_d   = rem_q;
    fcnt_d  = fcnt_q;
    if (power_pellet) begin
      saved_d = mode_q == MODE_FRIGHT ? saved_q : mode_q;
      mode_d  = MODE_FRIGHT;
      fcnt_d  = FW'(FRIGHT_TICKS);
    end else if (move_tick && mode_q == MODE_FRIGHT) begin
      fcnt_d = fcnt_q - FW'(1);
      mode_d = fcnt_q == FW'(1) ? saved_q : mode_q;
    end else if (move_tick) begin
      mode_d = rem_q == RW'(1) ? (mode_q == MODE_SCATTER ? MODE_CHASE : MODE_SCATTER) : mode_q;
      rem_d  = rem_q == RW'(1) ? (mode_q == MODE_SCATTER ? RW'(CHASE_TICKS) : RW'(SCATTER_TICKS))
                               : rem_q - RW'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_SCATTER;
      saved_q <= MODE_SCATTER;
      rem_q   <= RW'(SCATTER_TICKS);
      fcnt_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      saved_q <= saved_d;
      rem_q   <= rem_d;
      fcnt_q  <= fcnt_d;
    end
  end
  assign mode = mode_q;
endmodule

// File: rtl/ghost_step_sequencer.sv
// ghost_step_sequencer: steps each ghost controller in turn per move tick and reports collisions
module ghost_step_sequencer
  import ghost_step_sequencer_pkg::*;
#(
  parameter int NUM_GHOSTS    = 4,
  parameter int STEP_TIMEOUT  = 8,
  parameter int SCATTER_TICKS = 70,
  parameter int CHASE_TICKS   = 200,
  parameter int FRIGHT_TICKS  = 60
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     move_tick,
  input  logic                     power_pellet,
  input  logic [XW-1:0]            pac_x,
  input  logic [YW-1:0]            pac_y,
  input  logic [NUM_GHOSTS*XW-1:0] ghost_x,
  input  logic [NUM_GHOSTS*YW-1:0] ghost_y,
  input  logic [NUM_GHOSTS-1:0]    step_done,
  output logic [NUM_GHOSTS-1:0]    step_req,
  output mode_e                    mode,
  output logic                     collide,
  output logic [(NUM_GHOSTS > 1 ? $clog2(NUM_GHOSTS) : 1)-1:0] collide_id,
  output logic                     collide_fright,
  output logic                     round_done,
  output logic                     busy,
  output logic                     overrun,
  output logic                     step_timeout
);
  localparam int IW = NUM_GHOSTS > 1 ? $clog2(NUM_GHOSTS) : 1;
  localparam int CW = STEP_TIMEOUT > 1 ? $clog2(STEP_TIMEOUT) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, collide_id_q, collide_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_GHOSTS-1:0] step_req_q, step_req_d;
  logic collide_q, collide_d, collide_fright_q, collide_fright_d;
  logic round_done_q, round_done_d, busy_q, busy_d;
  logic overrun_q, overrun_d, step_timeout_q, step_timeout_d;
  logic done_i, to_i, hit;
  ghost_mode_timer #(
    .SCATTER_TICKS(SCATTER_TICKS),
    .CHASE_TICKS  (CHASE_TICKS),
    .FRIGHT_TICKS (FRIGHT_TICKS)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .move_tick   (move_tick),
    .power_pellet(power_pellet),
    .mode        (mode)
  );
  always_comb begin
    done_i  = step_done[idx_q];
    to_i    = state_q == S_WAIT && !done_i && cnt_q == CW'(STEP_TIMEOUT - 1);
    hit     = state_q == S_CHECK && ghost_x[idx_q*XW +: XW] == pac_x && ghost_y[idx_q*YW +: YW] == pac_y;
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (move_tick) begin
                 state_d = S_REQ;
                 idx_d   = '0;
               end
      S_REQ:   begin
                 state_d = S_WAIT;
                 cnt_d   = '0;
               end
      S_WAIT:  begin
                 cnt_d   = cnt_q + CW'(1);
                 state_d = done_i || to_i ? S_CHECK : S_WAIT;
               end
      S_CHECK: begin
                 state_d = idx_q == IW'(NUM_GHOSTS - 1) ? S_DONE : S_REQ;
                 idx_d   = idx_q == IW'(NUM_GHOSTS - 1) ? idx_q : idx_q + IW'(1);
               end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so they are derived from the state being entered.
    step_req_d       = state_d == S_REQ ? NUM_GHOSTS'(1) << idx_d : '0;
    collide_d        = hit;
    collide_id_d     = hit ? idx_q : collide_id_q;
    collide_fright_d = hit ? mode == MODE_FRIGHT : collide_fright_q;
    round_done_d     = state_d == S_DONE;
    busy_d           = state_d != S_IDLE;
    overrun_d        = move_tick && state_q != S_IDLE;
    step_timeout_d   = to_i;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      step_req_q       <= '0;
      collide_q        <= 1'b0;
      collide_id_q     <= '0;
      collide_fright_q <= 1'b0;
      round_done_q     <= 1'b0;
      busy_q           <= 1'b0;
      overrun_q        <= 1'b0;
      step_timeout_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      step_req_q       <= step_req_d;
      collide_q        <= collide_d;
      collide_id_q     <= collide_id_d;
      collide_fright_q <= collide_fright_d;
      round_done_q     <= round_done_d;
      busy_q           <= busy_d;
      overrun_q        <= overrun_d;
      step_timeout_q   <= step_timeout_d;
    end
  end
  assign step_req       = step_req_q;
  assign collide        = collide_q;
  assign collide_id     = collide_id_q;
  assign collide_fright = collide_fright_q;
  assign round_done     = round_done_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;
  assign step_timeout   = step_timeout_q;
endmodule
